// File: rtl/nibbler_sequencer.sv
// Instruction sequencer for the Nibbler 4-bit core: fetches, decodes and
// drives one-cycle datapath enables, with a ready/timeout handshake to data RAM.
module nibbler_sequencer #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
    input  logic       ram_rdy,
    input  logic       start,
    output logic       ir_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_en,
    output logic       flags_en,
    output logic [2:0] alu_sel,
    output logic       ram_cs,
    output logic       ram_we,
    output logic       in_en,
    output logic       out_en,
    output logic [3:0] imm,
    output logic       halted,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_CMPI  = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_IN    = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JC    = 4'hB;
    localparam logic [3:0] OP_JZ    = 4'hC;
    localparam logic [3:0] OP_JNZ   = 4'hD;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [2:0] ALU_IMM  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_RAM  = 3'b100;
    localparam logic [2:0] ALU_IN   = 3'b101;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    ir;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    opcode;
    logic          timeout_hit;

    assign opcode      = ir[7:4];
    assign imm         = ir[3:0];
    assign timeout_hit = (state == S_MEM) && !ram_rdy && (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                ir <= instr;
            // The counter is cleared on the way into MEM so every access gets a full budget
            if (state == S_EXEC)
                wait_cnt <= '0;
            else if (state == S_MEM && !ram_rdy)
                wait_cnt <= wait_cnt + CW'(1);
            if (timeout_hit)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_en     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_en    = 1'b0;
        flags_en  = 1'b0;
        alu_sel   = ALU_IMM;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        in_en     = 1'b0;
        out_en    = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_en     = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LIT:   begin alu_sel = ALU_IMM;  acc_en = 1'b1; flags_en = 1'b1; end
                    OP_ADDI:  begin alu_sel = ALU_ADD;  acc_en = 1'b1; flags_en = 1'b1; end
                    OP_SUBI:  begin alu_sel = ALU_SUB;  acc_en = 1'b1; flags_en = 1'b1; end
                    OP_NANDI: begin alu_sel = ALU_NAND; acc_en = 1'b1; flags_en = 1'b1; end
                    OP_CMPI:  begin alu_sel = ALU_SUB;  flags_en = 1'b1; end
                    OP_LD:    begin ram_cs = 1'b1; state_nxt = S_MEM; end
                    OP_ST:    begin ram_cs = 1'b1; ram_we = 1'b1; state_nxt = S_MEM; end
                    OP_IN:    begin in_en = 1'b1; alu_sel = ALU_IN; acc_en = 1'b1; flags_en = 1'b1; end
                    OP_OUT:   out_en  = 1'b1;
                    OP_JMP:   pc_load = 1'b1;
                    OP_JC:    pc_load = c_flag;
                    OP_JZ:    pc_load = z_flag;
                    OP_JNZ:   pc_load = !z_flag;
                    OP_HLT:   state_nxt = S_HALT;
                    default:  ;
                endcase
            end
            S_MEM: begin
                ram_cs = 1'b1;
                ram_we = (opcode == OP_ST);
                if (ram_rdy) begin
                    if (opcode == OP_LD) begin
                        alu_sel  = ALU_RAM;
                        acc_en   = 1'b1;
                        flags_en = 1'b1;
                    end
                    state_nxt = S_FETCH;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        // Reset parks the FSM in FETCH, so its enables must be suppressed explicitly
        if (!reset) begin
            ir_en    = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            acc_en   = 1'b0;
            flags_en = 1'b0;
            ram_cs   = 1'b0;
            ram_we   = 1'b0;
            in_en    = 1'b0;
            out_en   = 1'b0;
        end
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Self-checking bench for nibbler_sequencer: directed vector table, randomized
// instruction stream against an instruction-level model, and timeout/reset sequences.
module tb_nibbler_sequencer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instr = '0;
    logic       c_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       ram_rdy = 1'b0;
    logic       start = 1'b0;
    logic       ir_en, pc_inc, pc_load, acc_en, flags_en;
    logic [2:0] alu_sel;
    logic       ram_cs, ram_we, in_en, out_en;
    logic [3:0] imm;
    logic       halted, err;

    nibbler_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .c_flag(c_flag), .z_flag(z_flag),
        .ram_rdy(ram_rdy), .start(start), .ir_en(ir_en), .pc_inc(pc_inc),
        .pc_load(pc_load), .acc_en(acc_en), .flags_en(flags_en), .alu_sel(alu_sel),
        .ram_cs(ram_cs), .ram_we(ram_we), .in_en(in_en), .out_en(out_en),
        .imm(imm), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    // Vector layout: ir_en pc_inc pc_load acc_en flags_en alu_sel[2:0] ram_cs ram_we in_en out_en halted
    localparam logic [12:0] V_NONE  = 13'b0;
    localparam logic [12:0] V_FETCH = 13'b1100000000000;
    localparam logic [12:0] V_HALT  = 13'b0000000000001;

    logic [12:0] act;
    assign act = {ir_en, pc_inc, pc_load, acc_en, flags_en, alu_sel, ram_cs, ram_we, in_en, out_en, halted};

    typedef struct {
        logic [7:0]  instr;
        logic        c, z, rdy, st;
        logic [12:0] exp;
        logic [3:0]  eimm;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic       acc, flg;
        logic [2:0] alu;
        logic       cs, we, inp, outp;
        logic [2:0] jmp;
        logic       mem, hlt;
    } op_t;

    vec_t vecs[$];
    op_t  optab[16];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   we_seen = 0;
    logic err_exp = 1'b0;
    logic [3:0] last_imm = 4'h0;

    function automatic logic [12:0] mk(input logic acc, flg, input logic [2:0] alu,
                                       input logic cs, we, inp, outp, pcl);
        return {1'b0, 1'b0, pcl, acc, flg, alu, cs, we, inp, outp, 1'b0};
    endfunction

    task automatic set_op(input int idx, input logic acc, flg, input logic [2:0] alu,
                          input logic cs, we, inp, outp, input logic [2:0] jmp,
                          input logic mem, hlt);
        optab[idx] = '{acc, flg, alu, cs, we, inp, outp, jmp, mem, hlt};
    endtask

    task automatic add_vec(input logic [7:0] i, input logic c, z, rdy, st,
                           input logic [12:0] e, input logic [3:0] eimm, input logic eerr);
        vecs.push_back('{i, c, z, rdy, st, e, eimm, eerr});
    endtask

    task automatic applyStimulus(input logic [7:0] i, input logic c, z, rdy, st);
        instr   = i;
        c_flag  = c;
        z_flag  = z;
        ram_rdy = rdy;
        start   = st;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] exp,
                               input logic [3:0] eimm, input logic eerr);
        tests_run++;
        if (act !== exp || imm !== eimm || err !== eerr) begin
            tests_failed++;
            $display("[TB] FAIL %s: got vec=%b imm=%h err=%b, expected vec=%b imm=%h err=%b",
                     name, act, imm, err, exp, eimm, eerr);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance to the next falling edge
    task automatic step(input string name, input logic [7:0] i, input logic c, z, rdy, st,
                        input logic [12:0] exp, input logic [3:0] eimm, input logic eerr);
        applyStimulus(i, c, z, rdy, st);
        checkOutput(name, exp, eimm, eerr);
        if (ram_we === 1'b1) we_seen++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic halt_cycles(input string name);
        int h;
        h = $urandom_range(0, 3);
        for (int k = 0; k < h; k++)
            step(name, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                 V_HALT, last_imm, err_exp);
        step(name, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             V_HALT, last_imm, err_exp);
    endtask

    task automatic run_random(input int count);
        for (int n = 0; n < count; n++) begin
            logic [3:0] op;
            logic [3:0] opnd;
            logic c, z, taken;
            op_t o;
            int waits;
            op   = 4'($urandom_range(0, 15));
            opnd = 4'($urandom);
            o    = optab[op];
            step("rnd_fetch", {op, opnd}, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), V_FETCH, last_imm, err_exp);
            last_imm = opnd;
            c = 1'($urandom);
            z = 1'($urandom);
            case (o.jmp)
                3'd1:    taken = 1'b1;
                3'd2:    taken = c;
                3'd3:    taken = z;
                3'd4:    taken = !z;
                default: taken = 1'b0;
            endcase
            step("rnd_exec", 8'($urandom), c, z, 1'($urandom), 1'($urandom),
                 mk(o.acc, o.flg, o.alu, o.cs, o.we, o.inp, o.outp, taken), last_imm, err_exp);
            if (o.mem) begin
                waits = $urandom_range(0, TIMEOUT);
                for (int w = 0; w < waits && w < TIMEOUT; w++)
                    step("rnd_memwait", 8'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                         1'($urandom), mk(0, 0, 3'b000, 1, o.we, 0, 0, 0), last_imm, err_exp);
                if (waits < TIMEOUT) begin
                    step("rnd_memdone", 8'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                         1'($urandom), (o.we ? mk(0, 0, 3'b000, 1, 1, 0, 0, 0)
                                             : mk(1, 1, 3'b100, 1, 0, 0, 0, 0)),
                         last_imm, err_exp);
                end else begin
                    err_exp = 1'b1;
                    halt_cycles("rnd_timeout_halt");
                end
            end else if (o.hlt) begin
                halt_cycles("rnd_halt");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    initial begin
        // Instruction semantics: acc flg alu cs we in out jmp mem hlt
        set_op(0,  0, 0, 3'b000, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(1,  1, 1, 3'b000, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(2,  1, 1, 3'b001, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(3,  1, 1, 3'b010, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(4,  1, 1, 3'b011, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(5,  0, 1, 3'b010, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(6,  0, 0, 3'b000, 1, 0, 0, 0, 3'd0, 1, 0);
        set_op(7,  0, 0, 3'b000, 1, 1, 0, 0, 3'd0, 1, 0);
        set_op(8,  1, 1, 3'b101, 0, 0, 1, 0, 3'd0, 0, 0);
        set_op(9,  0, 0, 3'b000, 0, 0, 0, 1, 3'd0, 0, 0);
        set_op(10, 0, 0, 3'b000, 0, 0, 0, 0, 3'd1, 0, 0);
        set_op(11, 0, 0, 3'b000, 0, 0, 0, 0, 3'd2, 0, 0);
        set_op(12, 0, 0, 3'b000, 0, 0, 0, 0, 3'd3, 0, 0);
        set_op(13, 0, 0, 3'b000, 0, 0, 0, 0, 3'd4, 0, 0);
        set_op(14, 0, 0, 3'b000, 0, 0, 0, 0, 3'd0, 0, 0);
        set_op(15, 0, 0, 3'b000, 0, 0, 0, 0, 3'd0, 0, 1);

        // Directed program: instr, c, z, rdy, start, expected vector, imm, err
        add_vec(8'h15, 0, 0, 0, 0, V_FETCH, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(1, 1, 3'b000, 0, 0, 0, 0, 0), 4'h5, 0);
        add_vec(8'h23, 0, 0, 0, 0, V_FETCH, 4'h5, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(1, 1, 3'b001, 0, 0, 0, 0, 0), 4'h3, 0);
        add_vec(8'h58, 0, 0, 0, 0, V_FETCH, 4'h3, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(0, 1, 3'b010, 0, 0, 0, 0, 0), 4'h8, 0);
        add_vec(8'hC4, 0, 1, 0, 0, V_FETCH, 4'h8, 0);
        add_vec(8'hFF, 0, 1, 0, 0, mk(0, 0, 3'b000, 0, 0, 0, 0, 1), 4'h4, 0);
        add_vec(8'hC6, 0, 0, 0, 0, V_FETCH, 4'h4, 0);
        add_vec(8'hFF, 0, 0, 0, 0, V_NONE, 4'h6, 0);
        add_vec(8'hD2, 0, 0, 0, 0, V_FETCH, 4'h6, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 0, 0, 0, 0, 1), 4'h2, 0);
        add_vec(8'h61, 0, 0, 1, 0, V_FETCH, 4'h2, 0);
        add_vec(8'hFF, 0, 0, 1, 0, mk(0, 0, 3'b000, 1, 0, 0, 0, 0), 4'h1, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 1, 0, 0, 0, 0), 4'h1, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 1, 0, 0, 0, 0), 4'h1, 0);
        add_vec(8'hFF, 0, 0, 1, 0, mk(1, 1, 3'b100, 1, 0, 0, 0, 0), 4'h1, 0);
        add_vec(8'hB0, 1, 0, 0, 0, V_FETCH, 4'h1, 0);
        add_vec(8'hFF, 1, 0, 0, 0, mk(0, 0, 3'b000, 0, 0, 0, 0, 1), 4'h0, 0);
        add_vec(8'h8A, 0, 0, 0, 0, V_FETCH, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(1, 1, 3'b101, 0, 0, 1, 0, 0), 4'hA, 0);
        add_vec(8'h97, 0, 0, 0, 0, V_FETCH, 4'hA, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 0, 0, 0, 1, 0), 4'h7, 0);
        add_vec(8'hF0, 0, 0, 0, 1, V_FETCH, 4'h7, 0);
        add_vec(8'hFF, 0, 0, 0, 1, V_NONE, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 1, 0, V_HALT, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 0, 0, V_HALT, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 0, 1, V_HALT, 4'h0, 0);
        add_vec(8'h0E, 0, 0, 0, 0, V_FETCH, 4'h0, 0);
        add_vec(8'hFF, 0, 0, 0, 0, V_NONE, 4'hE, 0);
        add_vec(8'hE3, 0, 0, 0, 0, V_FETCH, 4'hE, 0);
        add_vec(8'hFF, 0, 0, 0, 0, V_NONE, 4'h3, 0);
        add_vec(8'h10, 0, 0, 0, 0, V_FETCH, 4'h3, 0);
        add_vec(8'hFF, 0, 0, 0, 0, mk(1, 1, 3'b000, 0, 0, 0, 0, 0), 4'h0, 0);

        // Power-on reset
        @(negedge clk);
        applyStimulus(8'h00, 0, 0, 0, 0);
        checkOutput("reset_hold", V_NONE, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k])
            step($sformatf("vec%0d", k), vecs[k].instr, vecs[k].c, vecs[k].z, vecs[k].rdy,
                 vecs[k].st, vecs[k].exp, vecs[k].eimm, vecs[k].eerr);
        last_imm = 4'h0;

        run_random(200);

        // ST with ram_rdy stuck low until timeout
        we_seen = 0;
        step("st_fetch", 8'h75, 0, 0, 0, 0, V_FETCH, last_imm, err_exp);
        last_imm = 4'h5;
        step("st_exec", 8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 1, 1, 0, 0, 0), last_imm, err_exp);
        for (int w = 0; w < TIMEOUT; w++)
            step("st_wait", 8'hFF, 0, 0, 0, 0, mk(0, 0, 3'b000, 1, 1, 0, 0, 0), last_imm, err_exp);
        err_exp = 1'b1;
        step("st_timeout_halt", 8'hFF, 0, 0, 0, 0, V_HALT, last_imm, err_exp);
        tests_run++;
        if (we_seen != TIMEOUT + 1) begin
            tests_failed++;
            $display("[TB] FAIL st_we_cycles: got %0d ram_we cycles, expected %0d", we_seen, TIMEOUT + 1);
        end
        step("st_start", 8'hFF, 0, 0, 0, 1, V_HALT, last_imm, err_exp);
        step("st_resume", 8'h23, 0, 0, 0, 0, V_FETCH, last_imm, err_exp);

        // Reset asserted in the middle of an ADDI execute cycle
        applyStimulus(8'hFF, 0, 0, 0, 0);
        checkOutput("addi_exec", mk(1, 1, 3'b001, 0, 0, 0, 0, 0), 4'h3, err_exp);
        reset = 1'b0;
        #1;
        checkOutput("reset_async", V_NONE, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_held", V_NONE, 4'h0, 1'b0);
        reset = 1'b1;
        err_exp = 1'b0;
        #1;
        checkOutput("reset_release", V_FETCH, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nibbler_sequencer.md
# nibbler_sequencer

Instruction sequencer for the Nibbler 4-bit datapath. Latches each 8-bit instruction from program ROM, decodes it, and drives the one-cycle enables for the accumulator, flags register, program counter, data RAM and I/O ports. Handles a ready handshake with data RAM, including a timeout. Owns the only FSM in the core; every datapath register is a slave of its enables.

## Interface
- `TIMEOUT`, default 8: maximum number of cycles spent in MEM waiting for `ram_rdy`. Range 1..255.
- `clk` input 1: single core clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; forces the reset state immediately.
- `instr` input 8: ROM output at the current PC; `[7:4]` opcode, `[3:0]` immediate/operand.
- `c_flag` input 1: registered carry flag from the flags register.
- `z_flag` input 1: registered zero flag from the flags register.
- `ram_rdy` input 1: data RAM access complete.
- `start` input 1: leaves HALT when high.
- `ir_en` output 1: load instruction register (internal copy also kept).
- `pc_inc` output 1: PC += 1.
- `pc_load` output 1: PC ← jump target.
- `acc_en` output 1: accumulator load enable.
- `flags_en` output 1: flags register load enable.
- `alu_sel` output 3: ALU function. 000 pass immediate, 001 add, 010 sub, 011 nand, 100 pass RAM, 101 pass input port.
- `ram_cs` output 1: RAM chip select.
- `ram_we` output 1: RAM write enable.
- `in_en` output 1: drive input-port buffer.
- `out_en` output 1: load output-port register.
- `imm` output 4: registered IR operand nibble.
- `halted` output 1: high in HALT.
- `err` output 1: sticky flag for RAM timeout; cleared only by reset.

## Operation
- States: FETCH, EXEC, MEM, HALT. Internal 8-bit IR, plus a wait counter of width clog2(TIMEOUT+1).
- **FETCH**
  - `ir_en=1`, `pc_inc=1`; IR ← `instr`.
  - Next state: EXEC.
- **EXEC**: decode IR`[7:4]`; outputs are combinational from state and IR. All enables are 0 unless listed.
  - 0 NOP: no enables.
  - 1 LIT: `alu_sel=000`, `acc_en`, `flags_en`.
  - 2 ADDI: `alu_sel=001`, `acc_en`, `flags_en`.
  - 3 SUBI: `alu_sel=010`, `acc_en`, `flags_en`.
  - 4 NANDI: `alu_sel=011`, `acc_en`, `flags_en`.
  - 5 CMPI: `alu_sel=010`, `flags_en` only.
  - 6 LD: `ram_cs`; next state MEM.
  - 7 ST: `ram_cs`, `ram_we`; next state MEM.
  - 8 IN: `in_en`, `alu_sel=101`, `acc_en`, `flags_en`.
  - 9 OUT: `out_en`.
  - A JMP: `pc_load`.
  - B JC: `pc_load` if `c_flag`.
  - C JZ: `pc_load` if `z_flag`.
  - D JNZ: `pc_load` if `!z_flag`.
  - E: reserved, executes as NOP.
  - F HLT: next state HALT.
  - Next state is FETCH unless stated otherwise above.
- **MEM**
  - `ram_cs` held; `ram_we` held for ST.
  - If `ram_rdy`: LD asserts `alu_sel=100`, `acc_en`, `flags_en` in this same cycle; next state FETCH.
  - Else, wait counter increments; when it reaches TIMEOUT: set `err`, next state HALT.
  - Counter clears on MEM entry.
- **HALT**
  - All enables 0; `halted=1`.
  - `start=1` → FETCH next cycle. PC is not reset, so execution resumes after the HLT.
- Jump flags are sampled in EXEC. Flags written by the previous instruction are already registered at that point.

## Timing
- While `reset` is low, and on its release: state FETCH, IR=0, `imm=0`, `err=0`, wait counter 0, `halted=0`. All enables 0 while `reset` is low.
- First FETCH occurs on the first rising edge after `reset` deasserts.
- Cycles per instruction:
  - 2 for most instructions: FETCH plus EXEC.
  - 3+N for LD/ST, where N is the number of MEM cycles with `ram_rdy` low.
  - Untaken jumps also take 2.
- `ram_rdy` already high on the first MEM cycle: completes in that cycle (3 cycles total).
- `ram_rdy` is ignored outside MEM.
- Reset asserted mid-MEM: `ram_cs`/`ram_we` drop asynchronously, with no write completion guaranteed.
- `start` is ignored outside HALT.
- While `err=1`, HALT is still exitable via `start`; `err` stays set.
- No combinational path from `instr` to any output. Outputs depend on state, IR, flags and `ram_rdy` only.

## Test plan
- **Reset:** hold `reset` low 3 cycles mid-EXEC of ADDI → all enables 0 immediately; after release, `ir_en=1` on the first cycle.
- **Straight-line ALU:** LIT 5, ADDI 3, CMPI 8 → `acc_en` pulses at cycles 2 and 4 with `alu_sel` 000 then 001; CMPI gives `flags_en=1`, `acc_en=0`.
- **Conditional jumps:**
  - JZ with `z_flag=1` → `pc_load=1` in EXEC.
  - JZ with `z_flag=0` → `pc_load=0`.
  - JNC-style coverage: JNZ with `z_flag=0` → `pc_load=1`.
  - Each instruction takes exactly 2 cycles.
- **LD with `ram_rdy` delayed 2 cycles** → `ram_cs` high for 4 cycles; `acc_en`/`alu_sel=100` only on the `ram_rdy` cycle; next cycle is FETCH.
- **ST with `ram_rdy` stuck low, TIMEOUT=8** → `ram_we` high for 9 cycles (EXEC plus 8 MEM); then `halted=1`, `err=1`.
- **HLT then `start` pulse** → `halted` high until `start`; `ir_en` asserts the next cycle; `err` unchanged.
